// File: rtl/jt1942_sdram_arb.sv
// Five-requester round-robin SDRAM read arbiter with one read in flight at a time.
// Optional periodic autorefresh is built when JT1942_SDRAM_ARB_REFRESH_EN is defined.
module jt1942_sdram_arb #(
  parameter int LATENCY        = 3,
  parameter int REFRESH_PERIOD = 384,
  parameter int REFRESH_LEN    = 8,
  parameter int INIT_CYCLES    = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         downloading,
  input  logic [4:0]   req,
  input  logic [109:0] addr,
  output logic [4:0]   ok,
  output logic [15:0]  dout,
  output logic [21:0]  sdram_addr,
  output logic         sdram_rd,
  input  logic [15:0]  data_read,
  output logic         autorefresh,
  output logic         ready
);

  localparam int CMAX = (LATENCY > REFRESH_LEN) ? LATENCY : REFRESH_LEN;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(INIT_CYCLES + 1);

  if (LATENCY < 2 || REFRESH_LEN < 1 || REFRESH_PERIOD < 2 || INIT_CYCLES < 1) begin : g_param_check
    $error("jt1942_sdram_arb: unsupported parameter values");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REFRESH} state_t;

  state_t            state, nxt;
  logic [4:0][21:0]  addr_a;
  logic [2:0]        gnt;       // last granted requester, doubles as round-robin pointer
  logic [2:0]        gnt_nxt;
  logic              gnt_any;
  logic [3:0]        k;
  logic [4:0]        elig;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     init_cnt;
  logic              lat_done, ref_done, do_grant;
  logic              refresh_pend;

  assign addr_a = addr;

  // A requester whose ok is pulsing this cycle is not re-granted until it reasserts.
  assign elig = req & ~ok & {5{~downloading}};

  always_comb begin
    gnt_any = 1'b0;
    gnt_nxt = gnt;
    k       = 4'd0;
    for (int i = 1; i <= 5; i++) begin
      k = 4'(gnt) + 4'(i);
      if (k >= 4'd5) k = k - 4'd5;
      if (!gnt_any && elig[k]) begin
        gnt_any = 1'b1;
        gnt_nxt = k[2:0];
      end
    end
  end

  assign lat_done = (cnt == CW'(LATENCY - 1));
  assign ref_done = (cnt == CW'(REFRESH_LEN - 1));
  assign do_grant = (state == IDLE) && !refresh_pend && gnt_any;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (refresh_pend) nxt = REFRESH;
               else if (gnt_any) nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    if (lat_done) nxt = IDLE;
      REFRESH: if (ref_done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (downloading) nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= 3'd4;
      cnt        <= '0;
      ok         <= '0;
      dout       <= '0;
      sdram_addr <= '0;
      init_cnt   <= '0;
    end else begin
      ok  <= '0;
      cnt <= (nxt == state && (state == WAIT || state == REFRESH)) ? cnt + CW'(1) : '0;
      if (do_grant) begin
        gnt        <= gnt_nxt;
        sdram_addr <= addr_a[gnt_nxt];
      end
      if (state == WAIT && lat_done && !downloading) begin
        dout <= data_read;
        ok   <= 5'd1 << gnt;
      end
      if (init_cnt != IW'(INIT_CYCLES)) init_cnt <= init_cnt + IW'(1);
    end
  end

  assign sdram_rd = (state == ISSUE) && !downloading;
  assign ready    = (init_cnt == IW'(INIT_CYCLES)) && !downloading;

`ifdef JT1942_SDRAM_ARB_REFRESH_EN
  localparam int PW = $clog2(REFRESH_PERIOD);
  logic [PW-1:0] per_cnt;

  // Completion clears the flag even if another refresh falls due that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt      <= '0;
      refresh_pend <= 1'b0;
    end else begin
      per_cnt <= (per_cnt == PW'(REFRESH_PERIOD - 1)) ? '0 : per_cnt + PW'(1);
      if (state == REFRESH && ref_done && !downloading) refresh_pend <= 1'b0;
      else if (per_cnt == PW'(REFRESH_PERIOD - 1))      refresh_pend <= 1'b1;
    end
  end

  assign autorefresh = (state == REFRESH);
`else
  assign refresh_pend = 1'b0;
  assign autorefresh  = 1'b0;
`endif

endmodule
